audio_resampler: RTL and testbench

- Upstream feeder for the I2S output bridge.
- Takes irregular core audio samples (strobe-qualified, stereo, unsigned) in the `clk_audio` domain and box-car averages every sample in each output window.
- Emits one averaged stereo sample per output period (e.g. 48 kHz), generated by a fractional phase accumulator.
- The held `audio_l`/`audio_r` outputs drive the I2S bridge's channel inputs directly.

---
 rtl/audio_resampler.sv | 147 ++++++++++++++
 tb/tb_audio_resampler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/audio_resampler.sv
// Box-car averaging resampler: accumulates strobed stereo samples per output window
// and emits floor(sum / count) once per phase-accumulator tick via a serial divider.
module audio_resampler #(
  parameter int CHANNEL_WIDTH = 16,
  parameter int CLK_HZ        = 21477272,
  parameter int OUT_HZ        = 48000,
  parameter int COUNT_WIDTH   = 10
) (
  input  logic                     clk_audio,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic [CHANNEL_WIDTH-1:0] in_l,
  input  logic [CHANNEL_WIDTH-1:0] in_r,
  output logic [CHANNEL_WIDTH-1:0] audio_l,
  output logic [CHANNEL_WIDTH-1:0] audio_r,
  output logic                     out_valid
);

  localparam int SUM_WIDTH = CHANNEL_WIDTH + COUNT_WIDTH;
  localparam int IDX_WIDTH = $clog2(SUM_WIDTH);
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(SUM_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t                 state;
  logic [31:0]            acc;
  logic [32:0]            acc_sum;
  logic                   tick;
  logic                   pending;
  logic                   service;
  logic [SUM_WIDTH-1:0]   sum_l, sum_r;
  logic [COUNT_WIDTH-1:0] count;
  logic [IDX_WIDTH-1:0]   bit_idx;
  logic [SUM_WIDTH-1:0]   num_l, num_r, num_next_l, num_next_r;
  logic [COUNT_WIDTH-1:0] rem_l, rem_r, rem_next_l, rem_next_r;
  logic [COUNT_WIDTH-1:0] divisor;

  // One restoring-division step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, and shift the resulting quotient bit in.
  function automatic logic [COUNT_WIDTH+SUM_WIDTH-1:0] div_step(
    input logic [COUNT_WIDTH-1:0] rem,
    input logic [SUM_WIDTH-1:0]   num,
    input logic [COUNT_WIDTH-1:0] d
  );
    logic [COUNT_WIDTH:0] shifted;
    logic                 ge;
    shifted  = {rem, num[SUM_WIDTH-1]};
    ge       = (shifted >= {1'b0, d});
    div_step = {(ge ? shifted[COUNT_WIDTH-1:0] - d : shifted[COUNT_WIDTH-1:0]),
                num[SUM_WIDTH-2:0], ge};
  endfunction

  always_comb begin
    acc_sum = {1'b0, acc} + 33'(OUT_HZ);
    tick    = (acc_sum >= 33'(CLK_HZ));
    service = (state == IDLE) && (tick || pending) && !out_valid;
    {rem_next_l, num_next_l} = div_step(rem_l, num_l, divisor);
    {rem_next_r, num_next_r} = div_step(rem_r, num_r, divisor);
  end

  always_ff @(posedge clk_audio) begin
    if (reset)
      acc <= '0;
    else if (tick)
      acc <= 32'(acc_sum - 33'(CLK_HZ));
    else
      acc <= acc_sum[31:0];
  end

  // A sample arriving on the window-close cycle seeds the new window.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      sum_l <= '0;
      sum_r <= '0;
      count <= '0;
    end else if (service) begin
      sum_l <= sample_en ? SUM_WIDTH'(in_l) : '0;
      sum_r <= sample_en ? SUM_WIDTH'(in_r) : '0;
      count <= sample_en ? COUNT_WIDTH'(1) : '0;
    end else if (sample_en && (count != COUNT_MAX)) begin
      sum_l <= sum_l + SUM_WIDTH'(in_l);
      sum_r <= sum_r + SUM_WIDTH'(in_r);
      count <= count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_audio) begin
    if (reset)
      pending <= 1'b0;
    else if (service)
      pending <= 1'b0;
    else if (tick)
      pending <= 1'b1;
  end

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      audio_l   <= '0;
      audio_r   <= '0;
      bit_idx   <= '0;
      num_l     <= '0;
      num_r     <= '0;
      rem_l     <= '0;
      rem_r     <= '0;
      divisor   <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (service) begin
            if (count == '0) begin
              out_valid <= 1'b1;
            end else begin
              state   <= DIVIDE;
              bit_idx <= LAST_IDX;
              num_l   <= sum_l;
              num_r   <= sum_r;
              rem_l   <= '0;
              rem_r   <= '0;
              divisor <= count;
            end
          end
        end
        DIVIDE: begin
          num_l <= num_next_l;
          num_r <= num_next_r;
          rem_l <= rem_next_l;
          rem_r <= rem_next_r;
          if (bit_idx == '0) begin
            state     <= DONE;
            audio_l   <= num_next_l[CHANNEL_WIDTH-1:0];
            audio_r   <= num_next_r[CHANNEL_WIDTH-1:0];
            out_valid <= 1'b1;
          end else begin
            bit_idx <= bit_idx - IDX_WIDTH'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_resampler.sv
// Directed scoreboard bench for audio_resampler: a driver pushes hand-computed
// outputs when each window closes, monitors pop and compare on every out_valid.
module tb_audio_resampler;

  localparam int CW = 16;

  logic          clk_audio = 1'b0;
  logic          reset     = 1'b1;
  logic          sample_en = 1'b0;
  logic [CW-1:0] in_l      = '0;
  logic [CW-1:0] in_r      = '0;
  logic [CW-1:0] audio_l, audio_r;
  logic          out_valid;
  logic          sat_en    = 1'b0;
  logic [CW-1:0] sat_l     = '0;
  logic [CW-1:0] sat_r     = '0;
  logic [CW-1:0] sat_audio_l, sat_audio_r;
  logic          sat_valid;

  audio_resampler #(
    .CHANNEL_WIDTH(16), .CLK_HZ(4800000), .OUT_HZ(48000), .COUNT_WIDTH(10)
  ) dut (
    .clk_audio(clk_audio), .reset(reset), .sample_en(sample_en),
    .in_l(in_l), .in_r(in_r),
    .audio_l(audio_l), .audio_r(audio_r), .out_valid(out_valid)
  );

  audio_resampler #(
    .CHANNEL_WIDTH(16), .CLK_HZ(4800000), .OUT_HZ(48000), .COUNT_WIDTH(4)
  ) dut_sat (
    .clk_audio(clk_audio), .reset(reset), .sample_en(sat_en),
    .in_l(sat_l), .in_r(sat_r),
    .audio_l(sat_audio_l), .audio_r(sat_audio_r), .out_valid(sat_valid)
  );

  always #5 clk_audio = ~clk_audio;

  // Cycle index within the current reset epoch; cycle 1 follows the last reset edge.
  int cyc = 0;
  always @(posedge clk_audio) begin
    if (reset) cyc <= 1;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int            cycle;
    logic [CW-1:0] l;
    logic [CW-1:0] r;
  } exp_t;

  exp_t main_q[$];
  exp_t sat_q[$];
  exp_t em, es;
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input int l, input int r);
    exp_t e;
    e.cycle = c;
    e.l     = CW'(l);
    e.r     = CW'(r);
    return e;
  endfunction

  // Drive one cycle of both DUTs and push expectations on each window-closing tick.
  task automatic applyStimulus(input int epoch, input int k);
    sample_en = 1'b0; in_l = 16'hDEAD; in_r = 16'hBEEF;
    sat_en    = 1'b0; sat_l = 16'hDEAD; sat_r = 16'hBEEF;
    if (epoch == 0) begin
      if (k <= 199) begin
        sample_en = 1'b1; in_l = 16'h1234; in_r = 16'hFFFF;
        sat_en = 1'b1; sat_l = (k <= 15) ? 16'h0001 : 16'hFFFF; sat_r = 16'h0002;
      end
      if (k >= 200 && k <= 299) begin
        sample_en = 1'b1; in_l = k[0] ? 16'h0003 : 16'h0000; in_r = 16'h0010;
      end
      if (k == 350) begin sample_en = 1'b1; in_l = 16'h0500; in_r = 16'h0007; end
      if (k == 500) begin sample_en = 1'b1; in_l = 16'h0100; in_r = 16'h0200; end
      if (k == 650) begin sample_en = 1'b1; in_l = 16'h4444; in_r = 16'h5555; end
      case (k)
        100: begin main_q.push_back(mk(127, 'h1234, 'hFFFF)); sat_q.push_back(mk(121, 'h0001, 'h0002)); end
        200: begin main_q.push_back(mk(227, 'h1234, 'hFFFF)); sat_q.push_back(mk(221, 'hFFFF, 'h0002)); end
        300: begin main_q.push_back(mk(327, 'h0001, 'h0010)); sat_q.push_back(mk(301, 'hFFFF, 'h0002)); end
        400: begin main_q.push_back(mk(427, 'h0500, 'h0007)); sat_q.push_back(mk(401, 'hFFFF, 'h0002)); end
        500: begin main_q.push_back(mk(501, 'h0500, 'h0007)); sat_q.push_back(mk(501, 'hFFFF, 'h0002)); end
        600: begin main_q.push_back(mk(627, 'h0100, 'h0200)); sat_q.push_back(mk(601, 'hFFFF, 'h0002)); end
        700: sat_q.push_back(mk(701, 'hFFFF, 'h0002));
        default: ;
      endcase
    end else begin
      if (k == 50) begin sample_en = 1'b1; in_l = 16'h0ABC; in_r = 16'h0DEF; end
      if (k == 100) begin
        main_q.push_back(mk(127, 'h0ABC, 'h0DEF));
        sat_q.push_back(mk(101, 'h0000, 'h0000));
      end
    end
  endtask

  always @(negedge clk_audio) begin
    if (!reset && out_valid) begin
      if (main_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL main unexpected out_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        em = main_q.pop_front();
        checkOutput("main pulse cycle", cyc, em.cycle);
        checkOutput("main audio_l", int'(audio_l), int'(em.l));
        checkOutput("main audio_r", int'(audio_r), int'(em.r));
      end
    end
  end

  always @(negedge clk_audio) begin
    if (!reset && sat_valid) begin
      if (sat_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL sat unexpected out_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        es = sat_q.pop_front();
        checkOutput("sat pulse cycle", cyc, es.cycle);
        checkOutput("sat audio_l", int'(sat_audio_l), int'(es.l));
        checkOutput("sat audio_r", int'(sat_audio_r), int'(es.r));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk_audio);
    @(negedge clk_audio);
    checkOutput("reset audio_l", int'(audio_l), 0);
    checkOutput("reset audio_r", int'(audio_r), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset sat out_valid", int'(sat_valid), 0);
    @(posedge clk_audio); #1;
    reset = 1'b0;

    // Epoch 0 ends with a one-cycle reset five cycles into the window-7 division.
    for (int k = 1; k <= 705; k++) begin
      applyStimulus(0, k);
      if (k == 705) reset = 1'b1;
      @(posedge clk_audio); #1;
    end
    reset = 1'b0;
    @(negedge clk_audio);
    checkOutput("abort audio_l", int'(audio_l), 0);
    checkOutput("abort audio_r", int'(audio_r), 0);
    checkOutput("abort out_valid", int'(out_valid), 0);
    @(posedge clk_audio); #1;

    for (int k = 2; k <= 140; k++) begin
      applyStimulus(1, k);
      @(posedge clk_audio); #1;
    end

    checkOutput("main outstanding pulses", main_q.size(), 0);
    checkOutput("sat outstanding pulses", sat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
